// File: rtl/data_memory_arbiter_if.sv
// rtl/data_memory_arbiter_if.sv - request/response bundle between two requesters, the arbiter and data memory
// Purpose: groups the port A / port B request channels, the memory-side bus and busy.
// Ports (signals):
//   a_req/a_addr/a_wdata/a_wren/a_mode/a_unsigned  port A command, held until a_gnt
//   a_gnt/a_rvalid/a_rdata                         port A accept strobe and read response
//   b_*                                            same set for port B
//   mem_address/mem_data/mem_wren/mem_mode/mem_unsigned  command towards the data memory
//   mem_q                                          memory read data, one cycle after the access
//   busy                                           arbiter not idle
// Modports: slave = arbiter side, master = requesters + memory side.
interface data_memory_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_wren;
  logic [1:0]        a_mode;
  logic              a_unsigned;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_wren;
  logic [1:0]        b_mode;
  logic              b_unsigned;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [1:0]        mem_mode;
  logic              mem_unsigned;
  logic [DATA_W-1:0] mem_q;

  logic              busy;

  modport slave (
    input  a_req, a_addr, a_wdata, a_wren, a_mode, a_unsigned,
    input  b_req, b_addr, b_wdata, b_wren, b_mode, b_unsigned,
    input  mem_q,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_address, mem_data, mem_wren, mem_mode, mem_unsigned,
    output busy
  );

  modport master (
    output a_req, a_addr, a_wdata, a_wren, a_mode, a_unsigned,
    output b_req, b_addr, b_wdata, b_wren, b_mode, b_unsigned,
    output mem_q,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_address, mem_data, mem_wren, mem_mode, mem_unsigned,
    input  busy
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - two-port arbiter serialising CPU and loader accesses onto one data memory
// Purpose: grants one requester per transaction, captures its command, issues one memory
//   access cycle and, for reads, returns mem_q to the owner one cycle later.
// Ports:
//   clock  single clock, rising edge
//   reset  synchronous active-low reset
//   bus    data_memory_arbiter_if.slave (port A, port B, memory side, busy)
// Build option: MEM_ARB_FIXED_PRIO_EN - port A always wins simultaneous requests;
//   default build alternates winners round-robin.
module data_memory_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  data_memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q;
  logic              owner_q;        // 0 = port A, 1 = port B
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic              last_owner_q;   // 0 = port A, 1 = port B
`endif
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic              cmd_wren_q;
  logic [1:0]        cmd_mode_q;
  logic              cmd_unsigned_q;
  logic              mem_wren_q;
  logic              rvalid_q;

  logic              pick_b;
  logic              grant_en;
  logic              a_rvalid;
  logic              b_rvalid;

  always_comb begin
    pick_b   = 1'b0;
    grant_en = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    pick_b = bus.b_req & ~bus.a_req;
`else
    // On contention, the port that did not win last time goes first.
    pick_b = bus.b_req & (~bus.a_req | ~last_owner_q);
`endif
    // Gated by reset so no grant can be seen while reset is asserted.
    grant_en = reset & (state_q == IDLE) & (bus.a_req | bus.b_req);
  end

  assign bus.a_gnt = grant_en & ~pick_b;
  assign bus.b_gnt = grant_en & pick_b;

  // Reset also masks the response so an aborted read never shows rvalid.
  assign a_rvalid     = reset & rvalid_q & ~owner_q;
  assign b_rvalid     = reset & rvalid_q & owner_q;
  assign bus.a_rvalid = a_rvalid;
  assign bus.b_rvalid = b_rvalid;
  assign bus.a_rdata  = a_rvalid ? bus.mem_q : '0;
  assign bus.b_rdata  = b_rvalid ? bus.mem_q : '0;

  // The memory bus is driven straight from the command registers, so address,
  // data, mode and the unsigned flag hold the last command between accesses.
  assign bus.mem_address  = cmd_addr_q;
  assign bus.mem_data     = cmd_wdata_q;
  assign bus.mem_mode     = cmd_mode_q;
  assign bus.mem_unsigned = cmd_unsigned_q;
  assign bus.mem_wren     = mem_wren_q;
  assign bus.busy         = (state_q != IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_owner_q   <= 1'b1;
`endif
      cmd_addr_q     <= '0;
      cmd_wdata_q    <= '0;
      cmd_wren_q     <= 1'b0;
      cmd_mode_q     <= 2'b00;
      cmd_unsigned_q <= 1'b0;
      mem_wren_q     <= 1'b0;
      rvalid_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_en) begin
            owner_q        <= pick_b;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_owner_q   <= pick_b;
`endif
            cmd_addr_q     <= pick_b ? bus.b_addr     : bus.a_addr;
            cmd_wdata_q    <= pick_b ? bus.b_wdata    : bus.a_wdata;
            cmd_wren_q     <= pick_b ? bus.b_wren     : bus.a_wren;
            cmd_mode_q     <= pick_b ? bus.b_mode     : bus.a_mode;
            cmd_unsigned_q <= pick_b ? bus.b_unsigned : bus.a_unsigned;
            // Write strobe is registered here so it is high for the ACCESS cycle only.
            mem_wren_q     <= pick_b ? bus.b_wren     : bus.a_wren;
            state_q        <= ACCESS;
          end
        end
        ACCESS: begin
          mem_wren_q <= 1'b0;
          if (cmd_wren_q) begin
            state_q <= IDLE;
          end else begin
            rvalid_q <= 1'b1;
            state_q  <= RESP;
          end
        end
        RESP: begin
          rvalid_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          mem_wren_q <= 1'b0;
          rvalid_q   <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - self-checking bench for data_memory_arbiter
module tb_data_memory_arbiter;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  data_memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  data_memory_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  logic model_last;   // port of the most recent grant, 0 = A, 1 = B

  logic [7:0] ref_mem [logic [31:0]];
  logic [7:0] dev_mem [logic [31:0]];

  function automatic logic [7:0] rb(input bit dev, input logic [31:0] a);
    if (dev) return dev_mem.exists(a) ? dev_mem[a] : 8'h00;
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic int nbytes(input logic [1:0] md);
    return (md == 2'd0) ? 1 : (md == 2'd1) ? 2 : 4;
  endfunction

  // Mode 0 = byte, 1 = half, 2/3 = word; little-endian byte-addressed memory.
  function automatic logic [31:0] mem_load(input bit dev, input logic [31:0] a,
                                           input logic [1:0] md, input logic un);
    logic [31:0] raw;
    raw = {rb(dev, a + 32'd3), rb(dev, a + 32'd2), rb(dev, a + 32'd1), rb(dev, a)};
    case (md)
      2'd0:    return un ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'd1:    return un ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic void mem_store(input bit dev, input logic [31:0] a,
                                    input logic [31:0] d, input logic [1:0] md);
    for (int i = 0; i < nbytes(md); i++) begin
      if (dev) dev_mem[a + 32'(i)] = d[8*i +: 8];
      else     ref_mem[a + 32'(i)] = d[8*i +: 8];
    end
  endfunction

  // Data memory: writes on mem_wren, read data registered one cycle after the access.
  always @(posedge clock) begin
    if (bus.mem_wren) mem_store(1'b1, bus.mem_address, bus.mem_data, bus.mem_mode);
    bus.mem_q <= mem_load(1'b1, bus.mem_address, bus.mem_mode, bus.mem_unsigned);
  end

  task automatic drive(input int p, input logic req, input logic [31:0] addr,
                       input logic [31:0] wd, input logic wr, input logic [1:0] md,
                       input logic un);
    if (p == 0) begin
      bus.a_req = req; bus.a_addr = addr; bus.a_wdata = wd;
      bus.a_wren = wr; bus.a_mode = md; bus.a_unsigned = un;
    end else begin
      bus.b_req = req; bus.b_addr = addr; bus.b_wdata = wd;
      bus.b_wren = wr; bus.b_mode = md; bus.b_unsigned = un;
    end
  endtask

  task automatic to_drive;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(0, 1'b1, 32'h10, 32'h1111_1111, 1'b1, 2'd2, 1'b1);
    drive(1, 1'b1, 32'h20, 32'h2222_2222, 1'b0, 2'd2, 1'b1);
    repeat (2) begin
      @(negedge clock);
      total++;
      if ({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.busy, bus.mem_wren, bus.mem_unsigned} !== 7'b0) begin
        bad++;
        $display("FAIL reset_ctrl: got %b expected 0", {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.busy, bus.mem_wren, bus.mem_unsigned});
      end
      total++;
      if ({bus.a_rdata, bus.b_rdata, bus.mem_address, bus.mem_data, bus.mem_mode} !== 130'b0) begin
        bad++;
        $display("FAIL reset_data: got %h expected 0", {bus.a_rdata, bus.b_rdata, bus.mem_address, bus.mem_data, bus.mem_mode});
      end
    end
    model_last = 1'b1;
    to_drive();
    reset = 1'b1;
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    @(negedge clock);
    total++;
    if ({bus.a_gnt, bus.b_gnt, bus.busy} !== 3'b000) begin
      bad++; $display("FAIL reset_release: got %b expected 000", {bus.a_gnt, bus.b_gnt, bus.busy});
    end
  endtask

  task automatic test_write_latency;
    to_drive();
    drive(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, 2'd2, 1'b0);
    @(negedge clock);
    total++;
    if ({bus.a_gnt, bus.b_gnt, bus.busy} !== 3'b100) begin
      bad++; $display("FAIL wr_gnt: got %b expected 100", {bus.a_gnt, bus.b_gnt, bus.busy});
    end
    mem_store(1'b0, 32'h10, 32'hDEAD_BEEF, 2'd2);
    model_last = 1'b0;
    to_drive();
    drive(0, 1'b0, 32'hFFFF_FFF0, 32'h1234_5678, 1'b0, 2'd0, 1'b1);
    @(negedge clock);
    total++;
    if ({bus.mem_wren, bus.busy, bus.a_gnt} !== 3'b110) begin
      bad++; $display("FAIL wr_access_ctrl: got %b expected 110", {bus.mem_wren, bus.busy, bus.a_gnt});
    end
    total++;
    if ({bus.mem_address, bus.mem_data, bus.mem_mode} !== {32'h10, 32'hDEAD_BEEF, 2'd2}) begin
      bad++; $display("FAIL wr_access_cmd: got %h expected %h", {bus.mem_address, bus.mem_data, bus.mem_mode}, {32'h10, 32'hDEAD_BEEF, 2'd2});
    end
    to_drive();
    @(negedge clock);
    total++;
    if ({bus.busy, bus.mem_wren, bus.mem_address} !== {2'b00, 32'h10}) begin
      bad++; $display("FAIL wr_done: got %h expected %h", {bus.busy, bus.mem_wren, bus.mem_address}, {2'b00, 32'h10});
    end
  endtask

  task automatic test_read_latency;
    to_drive();
    drive(1, 1'b1, 32'h10, 32'h0, 1'b0, 2'd2, 1'b0);
    @(negedge clock);
    total++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b01) begin
      bad++; $display("FAIL rd_gnt: got %b expected 01", {bus.a_gnt, bus.b_gnt});
    end
    model_last = 1'b1;
    to_drive();
    drive(1, 1'b0, 32'h0, 32'h0, 1'b1, 2'd0, 1'b0);
    @(negedge clock);
    total++;
    if ({bus.busy, bus.mem_wren, bus.a_rvalid, bus.b_rvalid} !== 4'b1000) begin
      bad++; $display("FAIL rd_access: got %b expected 1000", {bus.busy, bus.mem_wren, bus.a_rvalid, bus.b_rvalid});
    end
    to_drive();
    @(negedge clock);
    total++;
    if ({bus.a_rvalid, bus.b_rvalid, bus.a_rdata, bus.b_rdata} !== {2'b01, 32'h0, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL rd_resp: got %h expected %h", {bus.a_rvalid, bus.b_rvalid, bus.a_rdata, bus.b_rdata}, {2'b01, 32'h0, 32'hDEAD_BEEF});
    end
    to_drive();
    @(negedge clock);
    total++;
    if ({bus.a_rvalid, bus.b_rvalid, bus.busy, bus.b_rdata} !== 35'b0) begin
      bad++; $display("FAIL rd_after: got %h expected 0", {bus.a_rvalid, bus.b_rvalid, bus.busy, bus.b_rdata});
    end
  endtask

  task automatic test_round_robin;
    int   gq[$];
    int   e;
    to_drive();
    drive(0, 1'b1, 32'h100, 32'hA0A0_0001, 1'b1, 2'd2, 1'b0);
    drive(1, 1'b1, 32'h200, 32'hB0B0_0002, 1'b1, 2'd2, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      total++;
      if (bus.a_gnt && bus.b_gnt) begin
        bad++; $display("FAIL rr_double_gnt: got 11 expected at most one");
      end
      if (bus.a_gnt) begin gq.push_back(0); mem_store(1'b0, 32'h100, 32'hA0A0_0001, 2'd2); end
      if (bus.b_gnt) begin gq.push_back(1); mem_store(1'b0, 32'h200, 32'hB0B0_0002, 2'd2); end
      to_drive();
    end
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    total++;
    if (gq.size() != 6) begin
      bad++; $display("FAIL rr_count: got %0d expected 6", gq.size());
    end
    for (int i = 0; i < gq.size() && i < 6; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      e = 0;
`else
      e = model_last ? 0 : 1;
`endif
      model_last = (e == 1);
      total++;
      if (gq[i] != e) begin
        bad++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, gq[i], e);
      end
    end
  endtask

  task automatic test_reset_abort;
    to_drive();
    drive(0, 1'b1, 32'h10, 32'h0, 1'b0, 2'd2, 1'b0);
    @(negedge clock);
    total++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin
      bad++; $display("FAIL abort_gnt: got %b expected 10", {bus.a_gnt, bus.b_gnt});
    end
    model_last = 1'b0;
    to_drive();
    @(negedge clock);
    total++;
    if ({bus.busy, bus.a_gnt} !== 2'b10) begin
      bad++; $display("FAIL abort_no_gnt_busy: got %b expected 10", {bus.busy, bus.a_gnt});
    end
    to_drive();
    reset = 1'b0;
    @(negedge clock);
    total++;
    if ({bus.a_rvalid, bus.b_rvalid, bus.a_gnt, bus.b_gnt, bus.a_rdata} !== 36'b0) begin
      bad++; $display("FAIL abort_resp: got %h expected 0", {bus.a_rvalid, bus.b_rvalid, bus.a_gnt, bus.b_gnt, bus.a_rdata});
    end
    to_drive();
    @(negedge clock);
    total++;
    if ({bus.busy, bus.a_gnt, bus.b_gnt, bus.mem_wren, bus.mem_address} !== 36'b0) begin
      bad++; $display("FAIL abort_idle: got %h expected 0", {bus.busy, bus.a_gnt, bus.b_gnt, bus.mem_wren, bus.mem_address});
    end
    model_last = 1'b1;
    to_drive();
    reset = 1'b1;
    @(negedge clock);
    total++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin
      bad++; $display("FAIL abort_regrant: got %b expected 10", {bus.a_gnt, bus.b_gnt});
    end
    model_last = 1'b0;
    to_drive();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    to_drive();
    @(negedge clock);
    total++;
    if ({bus.a_rvalid, bus.a_rdata} !== {1'b1, mem_load(1'b0, 32'h10, 2'd2, 1'b0)}) begin
      bad++; $display("FAIL abort_regrant_data: got %h expected %h", {bus.a_rvalid, bus.a_rdata}, {1'b1, mem_load(1'b0, 32'h10, 2'd2, 1'b0)});
    end
    to_drive();
    drive(1, 1'b1, 32'h80, 32'h55, 1'b1, 2'd2, 1'b0);
    @(negedge clock);
    total++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b01) begin
      bad++; $display("FAIL abort_wr_gnt: got %b expected 01", {bus.a_gnt, bus.b_gnt});
    end
    to_drive();
    reset = 1'b0;
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    drive(0, 1'b1, 32'h84, 32'h66, 1'b1, 2'd2, 1'b0);
    @(negedge clock);
    total++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b00) begin
      bad++; $display("FAIL abort_wr_no_gnt: got %b expected 00", {bus.a_gnt, bus.b_gnt});
    end
    to_drive();
    reset = 1'b1;
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    model_last = 1'b1;
    @(negedge clock);
    total++;
    if ({bus.mem_wren, bus.busy, bus.mem_address} !== 34'b0) begin
      bad++; $display("FAIL abort_wr_clear: got %h expected 0", {bus.mem_wren, bus.busy, bus.mem_address});
    end
  endtask

  task automatic test_sign_extension;
    to_drive();
    drive(0, 1'b1, 32'h13, 32'h80, 1'b1, 2'd0, 1'b0);
    @(negedge clock);
    total++;
    if (bus.a_gnt !== 1'b1) begin
      bad++; $display("FAIL sx_wr_gnt: got %b expected 1", bus.a_gnt);
    end
    mem_store(1'b0, 32'h13, 32'h80, 2'd0);
    model_last = 1'b0;
    to_drive();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    to_drive();
    drive(0, 1'b1, 32'h13, 32'h0, 1'b0, 2'd0, 1'b0);
    @(negedge clock);
    total++;
    if (bus.a_gnt !== 1'b1) begin
      bad++; $display("FAIL sx_rd_gnt: got %b expected 1", bus.a_gnt);
    end
    to_drive();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b1);
    to_drive();
    @(negedge clock);
    total++;
    if ({bus.a_rvalid, bus.a_rdata} !== {1'b1, 32'hFFFF_FF80}) begin
      bad++; $display("FAIL sx_signed: got %h expected %h", {bus.a_rvalid, bus.a_rdata}, {1'b1, 32'hFFFF_FF80});
    end
    to_drive();
    drive(0, 1'b1, 32'h13, 32'h0, 1'b0, 2'd0, 1'b1);
    @(negedge clock);
    total++;
    if (bus.a_gnt !== 1'b1) begin
      bad++; $display("FAIL sx_urd_gnt: got %b expected 1", bus.a_gnt);
    end
    to_drive();
    drive(0, 1'b0, 32'h13, 32'h0, 1'b0, 2'd0, 1'b0);
    @(negedge clock);
    total++;
    if (bus.mem_unsigned !== 1'b1) begin
      bad++; $display("FAIL sx_uns_access: got %b expected 1", bus.mem_unsigned);
    end
    to_drive();
    @(negedge clock);
    total++;
    if ({bus.a_rvalid, bus.mem_unsigned, bus.a_rdata} !== {2'b11, 32'h0000_0080}) begin
      bad++; $display("FAIL sx_unsigned: got %h expected %h", {bus.a_rvalid, bus.mem_unsigned, bus.a_rdata}, {2'b11, 32'h0000_0080});
    end
  endtask

  task automatic test_random;
    bit          p_req  [2];
    bit          gl     [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_data [2];
    logic        p_wr   [2];
    logic [1:0]  p_md   [2];
    logic        p_un   [2];
    int          free_at, wr_at, rd_at, e_own, w;
    logic [31:0] e_addr, e_data, e_rdata, exp_ard, exp_brd;
    logic [1:0]  e_mode, exp_g, exp_rv;
    logic        e_un, exp_busy;
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 0; gl[p] = 0; p_addr[p] = '0; p_data[p] = '0;
      p_wr[p] = 1'b0; p_md[p] = 2'd0; p_un[p] = 1'b0;
    end
    free_at = 0; wr_at = -1; rd_at = -1; e_own = 0;
    e_addr = '0; e_data = '0; e_rdata = '0; e_mode = '0; e_un = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      to_drive();
      for (int p = 0; p < 2; p++) begin
        if (gl[p]) begin
          // Granted requester lets go and scribbles its inputs; the access must not notice.
          p_req[p] = 0;
          drive(p, 1'b0, $urandom, $urandom, 1'($urandom), 2'($urandom), 1'($urandom));
        end else begin
          if (p_req[p] && $urandom_range(0, 7) == 0) begin
            p_req[p] = 0;
          end else if (!p_req[p] && $urandom_range(0, 1) == 1) begin
            p_req[p]  = 1;
            p_addr[p] = 32'($urandom_range(0, 63));
            p_data[p] = $urandom;
            p_wr[p]   = 1'($urandom);
            p_md[p]   = 2'($urandom_range(0, 2));
            p_un[p]   = 1'($urandom);
          end
          drive(p, p_req[p], p_addr[p], p_data[p], p_wr[p], p_md[p], p_un[p]);
        end
      end
      @(negedge clock);
      exp_busy = (cyc < free_at);
      w = -1;
      if (!exp_busy && (p_req[0] || p_req[1])) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        w = p_req[0] ? 0 : 1;
`else
        if (p_req[0] && p_req[1]) w = model_last ? 0 : 1;
        else                      w = p_req[0] ? 0 : 1;
`endif
      end
      exp_g = (w == 0) ? 2'b10 : (w == 1) ? 2'b01 : 2'b00;
      total++;
      if ({bus.a_gnt, bus.b_gnt} !== exp_g) begin
        bad++; $display("FAIL rnd_gnt cyc %0d: got %b expected %b", cyc, {bus.a_gnt, bus.b_gnt}, exp_g);
      end
      total++;
      if (bus.busy !== exp_busy) begin
        bad++; $display("FAIL rnd_busy cyc %0d: got %b expected %b", cyc, bus.busy, exp_busy);
      end
      gl[0] = (w == 0);
      gl[1] = (w == 1);
      if (w >= 0) begin
        model_last = (w == 1);
        if (p_wr[w]) begin
          mem_store(1'b0, p_addr[w], p_data[w], p_md[w]);
          e_addr = p_addr[w]; e_data = p_data[w]; e_mode = p_md[w];
          wr_at = cyc + 1; free_at = cyc + 2;
        end else begin
          e_rdata = mem_load(1'b0, p_addr[w], p_md[w], p_un[w]);
          e_un = p_un[w]; e_own = w;
          rd_at = cyc + 2; free_at = cyc + 3;
        end
      end
      total++;
      if (bus.mem_wren !== (cyc == wr_at)) begin
        bad++; $display("FAIL rnd_wren cyc %0d: got %b expected %b", cyc, bus.mem_wren, (cyc == wr_at));
      end
      if (cyc == wr_at) begin
        total++;
        if ({bus.mem_address, bus.mem_data, bus.mem_mode} !== {e_addr, e_data, e_mode}) begin
          bad++; $display("FAIL rnd_wcmd cyc %0d: got %h expected %h", cyc, {bus.mem_address, bus.mem_data, bus.mem_mode}, {e_addr, e_data, e_mode});
        end
      end
      exp_rv  = (cyc == rd_at) ? ((e_own == 0) ? 2'b10 : 2'b01) : 2'b00;
      exp_ard = (cyc == rd_at && e_own == 0) ? e_rdata : 32'h0;
      exp_brd = (cyc == rd_at && e_own == 1) ? e_rdata : 32'h0;
      total++;
      if ({bus.a_rvalid, bus.b_rvalid} !== exp_rv) begin
        bad++; $display("FAIL rnd_rvalid cyc %0d: got %b expected %b", cyc, {bus.a_rvalid, bus.b_rvalid}, exp_rv);
      end
      total++;
      if ({bus.a_rdata, bus.b_rdata} !== {exp_ard, exp_brd}) begin
        bad++; $display("FAIL rnd_rdata cyc %0d: got %h expected %h", cyc, {bus.a_rdata, bus.b_rdata}, {exp_ard, exp_brd});
      end
      if (cyc == rd_at) begin
        total++;
        if (bus.mem_unsigned !== e_un) begin
          bad++; $display("FAIL rnd_uns cyc %0d: got %b expected %b", cyc, bus.mem_unsigned, e_un);
        end
      end
    end
    to_drive();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_read_latency();
    test_round_robin();
    test_reset_abort();
    test_sign_extension();
    test_random();
    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
